ghash_ctrl: RTL and testbench

GHASH sequencing controller for the AES-GCM datapath. Accepts the hash subkey H, the AAD and ciphertext bit lengths, and a stream of 128-bit AAD/ciphertext blocks. It drives the GF(2^128) multiplier (`gf_mult128`, 3-cycle latency) with `X ^ block` and H, and folds each product back into the accumulator. After the last data block it appends the `len(A)||len(C)` block itself and emits the final GHASH value for the tag stage.

---
 rtl/ghash_ctrl.sv | 136 +++++++++++++
 tb/tb_ghash_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ghash_ctrl.sv
// GHASH sequencing controller for AES-GCM.
// Feeds X^block and H to an external 3-cycle GF(2^128) multiplier, folds each
// product back into X, then appends the len(A)||len(C) block and emits GHASH.
module ghash_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] h_key,
  input  logic [63:0]  len_a,
  input  logic [63:0]  len_c,
  input  logic [127:0] din,
  input  logic         din_valid,
  input  logic         din_last,
  output logic         din_ready,
  output logic [127:0] mul_a,
  output logic [127:0] mul_b,
  output logic         mul_vld,
  input  logic [127:0] mul_res,
  input  logic         mul_res_vld,
  output logic [127:0] ghash,
  output logic         ghash_vld,
  output logic         busy,
  output logic [31:0]  blk_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT,
    S_LEN,
    S_WAIT_LEN
  } state_t;

  state_t         state, state_nxt;
  logic [127:0]   h_q;
  logic [63:0]    la_q, lc_q;
  logic [127:0]   x_q;
  logic           last_q;
  logic [127:0]   ghash_q;
  logic           hs;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and combinational outputs
  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    ghash_vld = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (len_a == 64'd0 && len_c == 64'd0) ? S_LEN : S_DATA;
      end
      S_DATA: begin
        din_ready = 1'b1;
        if (din_valid) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mul_res_vld) state_nxt = last_q ? S_LEN : S_DATA;
      end
      S_LEN: begin
        state_nxt = S_WAIT_LEN;
      end
      S_WAIT_LEN: begin
        if (mul_res_vld) begin
          ghash_vld = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign hs = din_ready & din_valid;

  // The final product is bypassed onto ghash during the pulse so the
  // consumer sees the new value in the same cycle as ghash_vld; the
  // register then holds it until the next completion.
  assign ghash = ghash_vld ? mul_res : ghash_q;

  // Datapath: key/length latch, accumulator, operand issue, block count
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      la_q    <= '0;
      lc_q    <= '0;
      x_q     <= '0;
      last_q  <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_vld <= 1'b0;
      ghash_q <= '0;
      blk_cnt <= '0;
    end else begin
      mul_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            h_q     <= h_key;
            la_q    <= len_a;
            lc_q    <= len_c;
            x_q     <= '0;
            blk_cnt <= '0;
          end
        end
        S_DATA: begin
          if (hs) begin
            mul_a   <= x_q ^ din;
            mul_b   <= h_q;
            mul_vld <= 1'b1;
            last_q  <= din_last;
            blk_cnt <= blk_cnt + 32'd1;
          end
        end
        S_WAIT: begin
          if (mul_res_vld) x_q <= mul_res;
        end
        S_LEN: begin
          mul_a   <= x_q ^ {la_q, lc_q};
          mul_b   <= h_q;
          mul_vld <= 1'b1;
        end
        S_WAIT_LEN: begin
          if (mul_res_vld) ghash_q <= mul_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
module tb_ghash_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] h_key = '0;
  logic [63:0]  len_a = '0;
  logic [63:0]  len_c = '0;
  logic [127:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_last = 1'b0;
  logic         din_ready;
  logic [127:0] mul_a, mul_b;
  logic         mul_vld;
  logic [127:0] mul_res;
  logic         mul_res_vld;
  logic [127:0] ghash;
  logic         ghash_vld;
  logic         busy;
  logic [31:0]  blk_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  ghash_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .h_key(h_key), .len_a(len_a),
    .len_c(len_c), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_vld(mul_vld),
    .mul_res(mul_res), .mul_res_vld(mul_res_vld), .ghash(ghash),
    .ghash_vld(ghash_vld), .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] gf(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z, v;
    z = '0;
    v = b;
    for (int i = 127; i >= 0; i--) begin
      if (a[i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
    end
    return z;
  endfunction

  logic [2:0]   p_vld = '0;
  logic [127:0] r0 = '0, r1 = '0, r2 = '0;
  logic         frc_vld = 1'b0;
  logic [127:0] frc_res = '0;
  always @(posedge clk) begin
    if (rst) begin
      p_vld <= '0;
    end else begin
      p_vld <= {p_vld[1:0], mul_vld};
      r0 <= gf(mul_a, mul_b);
      r1 <= r0;
      r2 <= r1;
    end
  end
  assign mul_res_vld = p_vld[2] | frc_vld;
  assign mul_res     = frc_vld ? frc_res : r2;

  logic [127:0] mx, mh, mres;
  logic [63:0]  mla, mlc;
  int           nblk, last_hs, s_cyc;
  logic         saw_ready, saw_gv;

  localparam logic [127:0] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C2   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] G2   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] H3   = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] JUNK = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
  logic [127:0] blks [4] = '{128'h42831ec2217774244b7221b784d0d49c,
                             128'he3aa212f2c02a4e035c17e2329aca12e,
                             128'h21d514b25466931c7d8f6a5aac84aa05,
                             128'h1ba30b396a0aac973d58e091473f5985};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_msg(input logic [127:0] h, input logic [63:0] la,
                           input logic [63:0] lc, input logic [127:0] prev);
    h_key = h; len_a = la; len_c = lc; start = 1'b1;
    s_cyc = cyc;
    step();
    start = 1'b0;
    mh = h; mla = la; mlc = lc; mx = '0; nblk = 0;
    chk("start_busy", busy, 1'b1);
    chk("ghash_held", ghash, prev);
  endtask

  task automatic hs(input logic [127:0] d, input logic last, input logic gap);
    int t;
    din = d; din_last = last; din_valid = 1'b1; t = 0;
    while (!din_ready && t < 20) begin step(); t++; end
    chk("ready_timeout", din_ready, 1'b1);
    if (gap) chk("hs_gap", cyc - last_hs, 5);
    last_hs = cyc;
    step();
    nblk++;
    chk("mul_vld", mul_vld, 1'b1);
    chk("mul_a", mul_a, mx ^ d);
    chk("mul_b", mul_b, mh);
    chk("blk_cnt", blk_cnt, nblk);
    mx = gf(mx ^ d, mh);
  endtask

  task automatic finish_msg();
    int t;
    din_valid = 1'b0; din_last = 1'b0; t = 0; saw_ready = 1'b0;
    while (!ghash_vld && t < 40) begin saw_ready |= din_ready; step(); t++; end
    chk("gv_timeout", ghash_vld, 1'b1);
    mres = gf(mx ^ {mla, mlc}, mh);
    chk("ghash", ghash, mres);
    chk("final_blk_cnt", blk_cnt, nblk);
  endtask

  initial begin
    step(); step();
    chk("rst_ghash", ghash, 128'd0);
    chk("rst_blk", blk_cnt, 32'd0);
    chk("rst_muls", {mul_a, mul_b, mul_vld}, 257'd0);
    chk("rst_ctl", {din_ready, busy, ghash_vld}, 3'b000);
    rst = 1'b0;
    step();

    begin_msg(H1, 64'd0, 64'd0, 128'd0);
    finish_msg();
    chk("empty_lat", cyc - s_cyc, 5);
    chk("empty_no_ready", saw_ready, 1'b0);
    chk("empty_ghash", ghash, 128'd0);
    step();
    chk("empty_idle", {busy, ghash_vld}, 2'b00);

    begin_msg(H1, 64'd0, 64'd128, 128'd0);
    hs(C2, 1'b1, 1'b0);
    finish_msg();
    chk("tc2_lat", cyc - last_hs, 9);
    chk("tc2_ghash", ghash, G2);

    step();
    begin_msg(H3, 64'd0, 64'd512, G2);
    hs(blks[0], 1'b0, 1'b0);
    hs(blks[1], 1'b0, 1'b1);
    hs(blks[2], 1'b0, 1'b1);
    hs(blks[3], 1'b1, 1'b1);
    finish_msg();
    step();
    chk("b2b_idle", busy, 1'b0);
    chk("b2b_hold", ghash, mres);

    begin_msg(H1, 64'd128, 64'd128, mres);
    h_key = JUNK; len_a = JUNK[63:0]; len_c = JUNK[127:64]; start = 1'b1;
    step();
    start = 1'b0;
    chk("stray_start_data", {din_ready, blk_cnt}, {1'b1, 32'd0});
    frc_vld = 1'b1; frc_res = JUNK;
    step();
    frc_vld = 1'b0;
    chk("stray_res_data", {din_ready, mul_vld}, 2'b10);
    hs(blks[0], 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("stray_start_wait", {busy, din_ready}, 2'b10);
    hs(blks[1], 1'b1, 1'b0);
    finish_msg();
    step();

    begin_msg(H3, 64'd0, 64'd256, mres);
    hs(blks[2], 1'b0, 1'b0);
    hs(blks[3], 1'b0, 1'b1);
    din_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ghash", ghash, 128'd0);
    chk("mid_rst_blk", blk_cnt, 32'd0);
    chk("mid_rst_muls", {mul_a, mul_b, mul_vld}, 257'd0);
    chk("mid_rst_ctl", {din_ready, busy, ghash_vld}, 3'b000);
    saw_gv = 1'b0;
    for (int i = 0; i < 8; i++) begin saw_gv |= ghash_vld; step(); end
    chk("mid_rst_no_gv", saw_gv, 1'b0);

    begin_msg(H1, 64'd0, 64'd128, 128'd0);
    hs(C2, 1'b1, 1'b0);
    finish_msg();
    chk("post_rst_ghash", ghash, G2);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
